// File: rtl/imm_split_if.sv
// Stream bundle for imm_split: 32-bit constants in,
// 16-bit immediate fields out, valid/ready on both sides.
interface imm_split_if;
   logic [31:0] value_i;
   logic        valid_i;
   logic        ready_o;
   logic [15:0] data_o;
   logic [1:0]  kind_o;
   logic        last_o;
   logic        valid_o;
   logic        ready_i;

   modport slave (
      input  value_i, valid_i, ready_i,
      output ready_o, data_o, kind_o, last_o, valid_o
   );

   modport master (
      output value_i, valid_i, ready_i,
      input  ready_o, data_o, kind_o, last_o, valid_o
   );
endinterface

// File: rtl/imm_split.sv
// Splits a 32-bit constant into SEXT, HI-only or HI+LO
// 16-bit immediate beats with registered outputs.
module imm_split #(
   parameter bit ZERO_LO_OPT = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   imm_split_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE,
      EMIT_ONE,
      EMIT_HI,
      EMIT_LO
   } state_e;

   localparam logic [1:0] K_SEXT = 2'b00;
   localparam logic [1:0] K_HI   = 2'b01;
   localparam logic [1:0] K_LO   = 2'b10;

   state_e      state_q;
   logic [31:0] value_q;
   logic [15:0] data_q;
   logic [1:0]  kind_q;
   logic        last_q;
   logic        valid_q;

   logic fits;
   logic lo_zero;

   assign fits    = bus.value_i[31:16] == {16{bus.value_i[15]}};
   assign lo_zero = bus.value_i[15:0] == 16'h0000;

   assign bus.ready_o = rst_i && (state_q == IDLE);
   assign bus.data_o  = data_q;
   assign bus.kind_o  = kind_q;
   assign bus.last_o  = last_q;
   assign bus.valid_o = valid_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         value_q <= 32'h0;
         data_q  <= 16'h0;
         kind_q  <= K_SEXT;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.valid_i) begin
                  value_q <= bus.value_i;
                  valid_q <= 1'b1;
                  if (fits) begin
                     state_q <= EMIT_ONE;
                     data_q  <= bus.value_i[15:0];
                     kind_q  <= K_SEXT;
                     last_q  <= 1'b1;
                  end else if (lo_zero && ZERO_LO_OPT) begin
                     state_q <= EMIT_ONE;
                     data_q  <= bus.value_i[31:16];
                     kind_q  <= K_HI;
                     last_q  <= 1'b1;
                  end else begin
                     state_q <= EMIT_HI;
                     data_q  <= bus.value_i[31:16];
                     kind_q  <= K_HI;
                     last_q  <= 1'b0;
                  end
               end
            end
            EMIT_HI: begin
               // held beat is refreshed from the holding register
               if (bus.ready_i) begin
                  state_q <= EMIT_LO;
                  data_q  <= value_q[15:0];
                  kind_q  <= K_LO;
                  last_q  <= 1'b1;
               end else begin
                  data_q  <= value_q[31:16];
               end
            end
            EMIT_ONE, EMIT_LO: begin
               if (bus.ready_i) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
